// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared FSM states, default widths and index-width helper for the systolic engine
package systolic_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DRAIN, DONE} state_t;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  // Bits needed to index n items, never less than one.
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - one output-stationary MAC cell with east/south operand pass registers
module systolic_pe import systolic_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk_buf,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     adv,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = a_in * b_in;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // Accumulate and forward operands only on an array step; wraps modulo 2^ACC_W.
  always_ff @(posedge clk_buf or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else if (clear) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else if (adv) begin
      acc   <= acc + prod_ext;
      a_out <= a_in;
      b_out <= b_in;
    end
  end

endmodule

// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - NxN systolic matrix multiply with input skew, stall and row drain
module systolic_mm_engine import systolic_pkg::*; #(
  parameter int N      = 8,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int K_W    = 10
) (
  input  logic                  clk_buf,
  input  logic                  rst,
  input  logic                  start,
  input  logic [K_W-1:0]        k_len,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   a_col,
  input  logic [N*DATA_W-1:0]   b_row,
  output logic                  c_valid,
  input  logic                  c_ready,
  output logic [N*ACC_W-1:0]    c_row,
  output logic [idx_w(N)-1:0]   c_row_idx,
  output logic                  c_last,
  output logic                  done
);

  localparam int RW = idx_w(N);
  localparam int FW = idx_w(2*N);

  state_t          state, state_nxt;
  logic [K_W-1:0]  k_reg, beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [RW-1:0]   row;
  logic            beat, adv, clr, accept, last_beat, flush_end, last_row;

  logic signed [DATA_W-1:0] a_h [N][N+1];
  logic signed [DATA_W-1:0] b_v [N+1][N];
  logic signed [ACC_W-1:0]  acc_q [N][N];

  assign beat      = (state == STREAM) && in_valid;
  assign adv       = beat || (state == FLUSH);
  assign clr       = (state == CLEAR);
  assign accept    = (state == DRAIN) && c_ready;
  assign last_beat = (beat_cnt == k_reg - K_W'(1));
  assign flush_end = (flush_cnt == FW'(2*N-2));
  assign last_row  = (row == RW'(N-1));

  // State register.
  always_ff @(posedge clk_buf or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    in_ready  = 1'b0;
    c_valid   = 1'b0;
    c_last    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR:  state_nxt = (k_reg != '0) ? STREAM : DRAIN;
      STREAM: begin
        in_ready = 1'b1;
        if (beat && last_beat) state_nxt = FLUSH;
      end
      FLUSH:  if (flush_end) state_nxt = DRAIN;
      DRAIN: begin
        c_valid = 1'b1;
        c_last  = last_row;
        if (accept && last_row) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // K capture plus beat, flush and drain-row counters.
  always_ff @(posedge clk_buf or posedge rst) begin
    if (rst) begin
      k_reg     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row       <= '0;
    end else begin
      if (state == IDLE && start) k_reg <= k_len;
      if (clr) begin
        beat_cnt  <= '0;
        flush_cnt <= '0;
        row       <= '0;
      end else begin
        if (beat)            beat_cnt  <= beat_cnt + K_W'(1);
        if (state == FLUSH)  flush_cnt <= flush_cnt + FW'(1);
        if (accept)          row       <= last_row ? '0 : row + RW'(1);
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_skew
    logic [DATA_W-1:0] a_src, b_src;
    logic              unused_edge;

    // Zeros are injected once the stream ends so the flush drains cleanly.
    assign a_src       = (state == STREAM) ? a_col[g*DATA_W +: DATA_W] : '0;
    assign b_src       = (state == STREAM) ? b_row[g*DATA_W +: DATA_W] : '0;
    assign unused_edge = ^{a_h[g][N], b_v[N][g]};

    if (g == 0) begin : g_direct
      assign a_h[0][0] = a_src;
      assign b_v[0][0] = b_src;
    end else begin : g_delay
      localparam int SW = g * DATA_W;
      logic [SW-1:0] a_sr, b_sr;

      // Row/column g enters the array g steps late.
      always_ff @(posedge clk_buf or posedge rst) begin
        if (rst) begin
          a_sr <= '0;
          b_sr <= '0;
        end else if (clr) begin
          a_sr <= '0;
          b_sr <= '0;
        end else if (adv) begin
          a_sr <= (a_sr << DATA_W) | SW'(a_src);
          b_sr <= (b_sr << DATA_W) | SW'(b_src);
        end
      end

      assign a_h[g][0] = a_sr[SW-1 -: DATA_W];
      assign b_v[0][g] = b_sr[SW-1 -: DATA_W];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk_buf (clk_buf),
        .rst     (rst),
        .clear   (clr),
        .adv     (adv),
        .a_in    (a_h[gi][gj]),
        .b_in    (b_v[gi][gj]),
        .a_out   (a_h[gi][gj+1]),
        .b_out   (b_v[gi+1][gj]),
        .acc     (acc_q[gi][gj])
      );
    end
  end

  // Present the accumulators of the current drain row.
  always_comb begin
    c_row = '0;
    for (int j = 0; j < N; j++) c_row[j*ACC_W +: ACC_W] = acc_q[row][j];
  end

  assign c_row_idx = row;

endmodule
